// File: rtl/counter_pkg.sv
// counter_pkg: mode encodings and reset values shared by the counter_param slice
package counter_pkg;
    typedef enum logic [1:0] {
        MODE_UP_STEP = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_UP      = 2'b10,
        MODE_LOAD    = 2'b11
    } mode_e;
    localparam logic RST_LOAD = 1'b0;
    localparam logic RST_RCO  = 1'b0;
endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next-count, wrap and load flags for one enabled edge
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STEP    = 3,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap,
    output logic             load_next
);
    localparam logic [WIDTH:0]   STEP_W = STEP[WIDTH:0];
    localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
    logic [WIDTH:0]   sum;
    logic             wrap_s, wrap_d, wrap_u;
    logic [WIDTH-1:0] q_s, q_d, q_u, q_l;
    always_comb begin
        // one extra bit so q+STEP never overflows before the modulus compare
        sum       = {1'b0, q} + STEP_W;
        wrap_s    = sum >= MOD_W;
        q_s       = WIDTH'(wrap_s ? sum - MOD_W : sum);
        wrap_d    = q == '0;
        q_d       = wrap_d ? MAX : q - WIDTH'(1);
        wrap_u    = q == MAX;
        q_u       = wrap_u ? '0 : q + WIDTH'(1);
        q_l       = d > MAX ? MAX : d;
        q_next    = mode == MODE_UP_STEP ? q_s : mode == MODE_DOWN ? q_d : mode == MODE_UP ? q_u : q_l;
        wrap      = mode == MODE_UP_STEP ? wrap_s : mode == MODE_DOWN ? wrap_d : mode == MODE_UP ? wrap_u : 1'b0;
        load_next = mode == MODE_LOAD;
    end
endmodule

// File: rtl/counter_param.sv
// counter_param: WIDTH-bit modulus-N counter with stride/down/up/load modes and registered load/rco pulses
module counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STEP    = 3,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             load,
    output logic             rco
);
    if (WIDTH < 2 || MODULUS < 2 || MODULUS > 2**WIDTH || STEP < 1 || STEP > MODULUS - 1) begin : g_bad_params
        $error("counter_param: parameters out of range");
    end
    logic [WIDTH-1:0] q_next;
    logic             wrap, load_next;
    counter_step #(.WIDTH(WIDTH), .STEP(STEP), .MODULUS(MODULUS)) u_step (
        .q(Q), .mode(mode), .d(D), .q_next(q_next), .wrap(wrap), .load_next(load_next)
    );
    // disabled cycles hold Q but still clear the pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= '0;
            load <= RST_LOAD;
            rco  <= RST_RCO;
        end else begin
            Q    <= enable ? q_next : Q;
            load <= enable & load_next;
            rco  <= enable & wrap;
        end
    end
endmodule
